jstk_spi_responder: RTL and testbench



---
 rtl/jstk_spi_responder_pkg.sv | 15 +
 rtl/jstk_spi_responder_pin_sync.sv | 40 ++++
 rtl/jstk_spi_responder.sv | 137 +++++++++++++
 tb/tb_jstk_spi_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/jstk_spi_responder_pkg.sv
// Shared constants and state type for the PmodJSTK SPI responder.
// The LED command byte is what a real initiator puts in the first byte of its frame.
package jstk_pkg;

  localparam int FRAME_BITS_DEFAULT = 40;
  localparam int FRAME_BYTES        = 5;
  localparam logic [7:0] LED_CMD    = 8'h84;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/jstk_spi_responder_pin_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, followed by a history flop
// so the caller gets the synchronized level plus single-cycle rise/fall strobes.
module spi_pin_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic hist_q, hist_d;

  always_comb begin
    meta_d = pin_i;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      hist_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~hist_q;
  assign fall_o  = ~sync_q & hist_q;

endmodule

// File: rtl/jstk_spi_responder.sv
// Mode-0 SPI responder emulating a PmodJSTK: shifts tx_data_i out MSB first and
// captures the initiator's command frame, all oversampled in the clk_i domain.
module jstk_spi_responder
  import jstk_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  spi_cs_i,
  input  logic                  spi_sck_i,
  input  logic                  spi_sd_i,
  output logic                  spi_sd_o,
  input  logic [FRAME_BITS-1:0] tx_data_i,
  output logic [FRAME_BITS-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(FRAME_BITS - 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic sd_lvl, sd_rise, sd_fall;
  logic unused_pin_strobes;

  spi_pin_sync #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk_i(clk_i), .reset_i(reset_i), .pin_i(spi_cs_i),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_pin_sync #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk_i(clk_i), .reset_i(reset_i), .pin_i(spi_sck_i),
    .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_pin_sync #(.RESET_VAL(1'b0)) u_sd_sync (
    .clk_i(clk_i), .reset_i(reset_i), .pin_i(spi_sd_i),
    .level_o(sd_lvl), .rise_o(sd_rise), .fall_o(sd_fall)
  );

  assign unused_pin_strobes = ^{sck_lvl, sd_rise, sd_fall};

  // rx_valid_o and err_o are single-cycle pulses with no ready/backpressure:
  // a consumer must take rx_data_o in the cycle rx_valid_o is high or lose it.
  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] tx_sr_q, tx_sr_d;
  logic [FRAME_BITS-1:0] rx_sr_q, rx_sr_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  err_q, err_d;
  logic [1:0]            flush_q, flush_d;

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    cnt_d      = cnt_q;
    rx_valid_d = 1'b0;
    err_d      = 1'b0;
    flush_d    = (flush_q == 2'd3) ? flush_q : flush_q + 2'd1;

    unique case (state_q)
      IDLE: begin
        // The CS chain resets high, so a pin held low through reset would look
        // like a falling edge until the history flop holds a real sample.
        if (cs_fall && (flush_q == 2'd3)) begin
          tx_sr_d = tx_data_i;
          rx_sr_d = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST_CNT) begin
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          state_d    = DONE;
        end else begin
          if (sck_rise) begin
            rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], sd_lvl};
            cnt_d   = cnt_q + 1'b1;
          end
          if (sck_fall) begin
            tx_sr_d = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
          end
          // A CS rise alongside the final sample still completes the frame;
          // DONE then leaves on the CS level.
          if (cs_rise && !(sck_rise && (cnt_q == PRE_LAST_CNT))) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        if (cs_lvl) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      flush_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      cnt_q      <= cnt_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
      flush_q    <= flush_d;
    end
  end

  assign spi_sd_o   = (state_q == SHIFT) & tx_sr_q[FRAME_BITS-1];
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Bench for jstk_spi_responder: acts as the mode-0 SPI initiator and compares
// MISO bits, received frames and pulse counts against a frame-level model.
module tb_jstk_spi_responder;

  localparam int FB = 40;

  logic          clk = 1'b0;
  logic          reset_i, spi_cs_i, spi_sck_i, spi_sd_i, spi_sd_o;
  logic [FB-1:0] tx_data_i, rx_data_o;
  logic          rx_valid_o, err_o, busy_o;

  jstk_spi_responder #(.FRAME_BITS(FB)) dut (
    .clk_i(clk), .reset_i(reset_i), .spi_cs_i(spi_cs_i), .spi_sck_i(spi_sck_i),
    .spi_sd_i(spi_sd_i), .spi_sd_o(spi_sd_o), .tx_data_i(tx_data_i),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic [FB-1:0] exp_q[$];
  logic [FB-1:0] exp_rx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rx_valid_o pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (reset_i === 1'b0) begin
      if (err_o === 1'b1) err_cnt++;
      if (rx_valid_o === 1'b1) begin
        valid_cnt++;
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_rx_valid observed=%h expected=no_pulse", rx_data_o);
        end
        if (exp_q.size() > 0) check("rx_frame", {24'b0, rx_data_o}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // MISO seen by the initiator: tx frame MSB first, zeros after the frame ends.
  function automatic logic [63:0] exp_miso(input logic [FB-1:0] tx, input int n);
    logic [63:0] r;
    r = {tx, 24'b0};
    for (int i = n; i < 64; i++) r[63-i] = 1'b0;
    return r;
  endfunction

  task automatic frame(input logic [63:0] mosi, input int nrise, input int half,
                       input int chg_at, input logic [FB-1:0] chg_val,
                       input bit cs_with_last, output logic [63:0] miso);
    miso = '0;
    spi_cs_i = 1'b0;
    tick(6);
    for (int i = 0; i < nrise; i++) begin
      spi_sd_i = mosi[63-i];
      tick(half);
      miso[63-i] = spi_sd_o;
      spi_sck_i = 1'b1;
      if (cs_with_last && (i == nrise - 1)) spi_cs_i = 1'b1;
      if (i == chg_at) tx_data_i = chg_val;
      tick(half);
      spi_sck_i = 1'b0;
    end
    tick(half);
    spi_cs_i = 1'b1;
    tick(8);
  endtask

  task automatic run(input string tag, input logic [FB-1:0] tx, input logic [63:0] mosi,
                     input int n, input int half, input bit cs_last,
                     input int chg_at, input logic [FB-1:0] chg_val);
    int v0, e0;
    logic [63:0] miso;
    v0 = valid_cnt;
    e0 = err_cnt;
    tx_data_i = tx;
    if (n >= FB) begin
      exp_q.push_back(mosi[63 -: FB]);
      exp_rx = mosi[63 -: FB];
    end
    frame(mosi, n, half, chg_at, chg_val, cs_last, miso);
    check({tag, "_miso"}, miso, exp_miso(tx, n));
    check({tag, "_rx_data"}, {24'b0, rx_data_o}, {24'b0, exp_rx});
    check({tag, "_valid_pulses"}, valid_cnt - v0, (n >= FB) ? 1 : 0);
    check({tag, "_err_pulses"}, err_cnt - e0, (n < FB) ? 1 : 0);
    check({tag, "_busy_after"}, busy_o, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rnd;
    logic [FB-1:0] tx;
    int v0, e0;

    reset_i = 1'b1; spi_cs_i = 1'b0; spi_sck_i = 1'b0; spi_sd_i = 1'b0; tx_data_i = '0;
    exp_rx = '0;
    tick(3);
    check("reset_sd_o", spi_sd_o, 0);
    check("reset_rx_data", {24'b0, rx_data_o}, 0);
    check("reset_rx_valid", rx_valid_o, 0);
    check("reset_err", err_o, 0);
    check("reset_busy", busy_o, 0);
    reset_i = 1'b0;
    tick(10);
    check("cs_low_after_reset_busy", busy_o, 0);
    check("cs_low_after_reset_pulses", valid_cnt + err_cnt, 0);
    spi_cs_i = 1'b1;
    tick(4);

    run("full", 40'h0123456789, {40'h84FF008000, 24'h0}, 40, 6, 1'b0, -1, '0);

    rnd = {$urandom, $urandom};
    run("short", {$urandom, 8'h5A}, rnd, 17, 5, 1'b0, -1, '0);

    rnd = {$urandom, $urandom};
    run("overrun", {8'hC3, $urandom}, rnd, 45, 4, 1'b0, -1, '0);

    rnd = {$urandom, $urandom};
    run("tx_change_f1", 40'h0123456789, rnd, 40, 5, 1'b0, 10, {FB{1'b1}});
    rnd = {$urandom, $urandom};
    run("tx_change_f2", {FB{1'b1}}, rnd, 40, 5, 1'b0, -1, '0);

    // Reset in the middle of a frame, CS held low across it.
    v0 = valid_cnt;
    e0 = err_cnt;
    tx_data_i = {$urandom, 8'hA5};
    spi_cs_i = 1'b0;
    tick(6);
    for (int i = 0; i < 20; i++) begin
      spi_sd_i = 1'($urandom_range(0, 1));
      tick(5);
      spi_sck_i = 1'b1;
      tick(5);
      spi_sck_i = 1'b0;
    end
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_busy", busy_o, 0);
    check("midreset_sd_o", spi_sd_o, 0);
    check("midreset_rx_data", {24'b0, rx_data_o}, 0);
    tick(2);
    reset_i = 1'b0;
    exp_rx = '0;
    tick(6);
    check("midreset_no_restart", busy_o, 0);
    spi_cs_i = 1'b1;
    tick(6);
    check("midreset_no_pulses", (valid_cnt - v0) + (err_cnt - e0), 0);
    rnd = {$urandom, $urandom};
    run("after_reset", {$urandom, 8'h3C}, rnd, 40, 6, 1'b0, -1, '0);

    rnd = {$urandom, $urandom};
    run("cs_with_last", {$urandom, 8'h96}, rnd, 40, 4, 1'b1, -1, '0);

    for (int k = 0; k < 6; k++) begin
      int n, half;
      bit csl;
      n = $urandom_range(1, 45);
      half = $urandom_range(4, 8);
      csl = 1'($urandom_range(0, 1));
      rnd = {$urandom, $urandom};
      tx = {$urandom, 8'($urandom)};
      run($sformatf("rand%0d_n%0d", k, n), tx, rnd, n, half, csl, -1, '0);
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
